// File: rtl/linked_fifo_reader_pkg.sv
// Shared types and helpers for the linked_fifo consumer side.
package linked_fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } rd_state_e;

    // Index width that never collapses to zero bits for single-entry configs.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/linked_fifo_skid.sv
// Small circular output buffer; count doubles as the occupancy used for credit.
module linked_fifo_skid
    import linked_fifo_reader_pkg::*;
#(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    localparam int PW = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap keeps non-power-of-2 depths correct.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (rd) rd_ptr <= bump(rd_ptr);
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/linked_fifo_reader.sv
// Round-robin drain of linked_fifo queues into a tagged valid/ready stream.
module linked_fifo_reader
    import linked_fifo_reader_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FIFOS      = 8,
    parameter int LOG2_FIFOS = idx_width(FIFOS),
    parameter int SKID_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_ready,
    input  logic [FIFOS-1:0]      enable,
    input  logic                  halt,
    output logic                  pop,
    output logic [LOG2_FIFOS-1:0] pop_fifo,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [LOG2_FIFOS-1:0] out_fifo,
    output logic                  busy
);
    localparam int CW  = $clog2(SKID_DEPTH + 1);
    localparam int PW1 = CW + 1;
    localparam logic [LOG2_FIFOS-1:0] LAST = LOG2_FIFOS'(FIFOS - 1);

    rd_state_e                 state;
    logic [LOG2_FIFOS-1:0]     scan_ptr;
    logic [LOG2_FIFOS-1:0]     tag;
    logic                      inflight;
    logic [CW-1:0]             occ;
    logic [WIDTH+LOG2_FIFOS-1:0] rdata;
    logic                      deq;
    logic                      en_cur;
    logic                      credit;
    logic [PW1-1:0]            pending;

    always_comb begin
        en_cur = 1'b0;
        for (int i = 0; i < FIFOS; i++)
            if (scan_ptr == LOG2_FIFOS'(i)) en_cur = enable[i];
    end

    assign out_valid = (occ != '0);
    assign deq       = out_valid && out_ready;
    // Words already committed to the buffer after this cycle's dequeue.
    assign pending   = PW1'(occ) + PW1'(inflight) - PW1'(deq);
    assign credit    = pending < PW1'(SKID_DEPTH);
    assign pop       = (state == RUN) && fifo_ready && !fifo_empty && en_cur && credit;
    assign pop_fifo  = scan_ptr;
    assign busy      = inflight || out_valid;
    assign {out_data, out_fifo} = rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            scan_ptr <= '0;
            inflight <= 1'b0;
            tag      <= '0;
        end else begin
            inflight <= pop;
            if (pop) tag <= scan_ptr;
            if (!fifo_ready) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    state <= RUN;
                    RUN:     if (halt) state <= HOLD;
                    HOLD:    if (!halt) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
            if (state == RUN) scan_ptr <= (scan_ptr == LAST) ? '0 : scan_ptr + 1'b1;
        end
    end

    // q arrives the cycle after pop, paired with the tag registered at the pop.
    linked_fifo_skid #(
        .WIDTH(WIDTH + LOG2_FIFOS),
        .DEPTH(SKID_DEPTH)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .wr   (inflight),
        .wdata({fifo_q, tag}),
        .rd   (deq),
        .rdata(rdata),
        .count(occ)
    );

endmodule
